// File: rtl/exc_pkg.sv
// Shared cause codes and sequencer state encoding for the exception controller.
package exc_pkg;

    localparam int CAUSE_ILLEGAL   = 1;
    localparam int CAUSE_ITLB_MISS = 2;
    localparam int CAUSE_DTLB_MISS = 3;
    localparam int CAUSE_PRIV      = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN_TRAP = 3'd1,
        ST_TRAP       = 3'd2,
        ST_DRAIN_RET  = 3'd3,
        ST_RETURN     = 3'd4,
        ST_HALT       = 3'd5
    } exc_state_e;

endpackage

// File: rtl/exc_priority_select.sv
// Combinational event arbiter: picks the single trap/return event
// presented to the sequencer while it sits in IDLE.
module exc_priority_select #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_addr,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_panic,
    input  logic               id_iret,
    input  logic               id_tlbwrite,
    input  logic               id_mov_rm,
    input  logic               priv_mode,
    output logic               take,
    output logic [CAUSE_W-1:0] cause,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    addr,
    output logic               is_ret
);
    import exc_pkg::*;

    logic priv_op;
    assign priv_op = id_iret | id_tlbwrite | id_mov_rm;

    always_comb begin
        take   = 1'b0;
        is_ret = 1'b0;
        cause  = '0;
        pc     = '0;
        addr   = '0;
        // The late-stage instruction is older, so it wins over decode.
        if (exc_valid) begin
            take  = 1'b1;
            cause = exc_cause;
            pc    = exc_pc;
            addr  = exc_addr;
        end else if (id_valid && id_panic) begin
            take  = 1'b1;
            cause = CAUSE_W'(CAUSE_ILLEGAL);
            pc    = id_pc;
        end else if (id_valid && priv_op && !priv_mode) begin
            take  = 1'b1;
            cause = CAUSE_W'(CAUSE_PRIV);
            pc    = id_pc;
        end else if (id_valid && id_iret) begin
            is_ret = 1'b1;
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Trap/return sequencer: drains stores, flushes, saves rm0-rm2, redirects fetch.
// Optional trap counter enabled by defining EXC_TRAP_COUNT_EN.
module exception_controller #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_2000,
    parameter int              CAUSE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_panic,
    input  logic               id_iret,
    input  logic               id_tlbwrite,
    input  logic               id_mov_rm,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_addr,
    input  logic               sb_empty,
    output logic               stall_id,
    output logic               flush_all,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    rm0,
    output logic [XLEN-1:0]    rm1,
    output logic [XLEN-1:0]    rm2,
    output logic               priv_mode,
    output logic               halted,
    output logic [31:0]        trap_count
);
    import exc_pkg::*;

    exc_state_e state, next;

    logic               take;
    logic               is_ret;
    logic [CAUSE_W-1:0] sel_cause;
    logic [XLEN-1:0]    sel_pc;
    logic [XLEN-1:0]    sel_addr;

    logic [CAUSE_W-1:0] pend_cause;
    logic [XLEN-1:0]    pend_pc;
    logic [XLEN-1:0]    pend_addr;

    exc_priority_select #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W)
    ) u_sel (
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_pc      (exc_pc),
        .exc_addr    (exc_addr),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_panic    (id_panic),
        .id_iret     (id_iret),
        .id_tlbwrite (id_tlbwrite),
        .id_mov_rm   (id_mov_rm),
        .priv_mode   (priv_mode),
        .take        (take),
        .cause       (sel_cause),
        .pc          (sel_pc),
        .addr        (sel_addr),
        .is_ret      (is_ret)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pend_cause <= '0;
            pend_pc    <= '0;
            pend_addr  <= '0;
            rm0        <= '0;
            rm1        <= '0;
            rm2        <= '0;
            priv_mode  <= 1'b1;
        end else begin
            state <= next;
            if (state == ST_IDLE && take && !priv_mode) begin
                pend_cause <= sel_cause;
                pend_pc    <= sel_pc;
                pend_addr  <= sel_addr;
            end
            // rm regs change only here, so an aborted drain leaves them intact.
            if (state == ST_TRAP) begin
                rm0       <= pend_pc;
                rm1       <= pend_addr;
                rm2       <= {{(XLEN-CAUSE_W){1'b0}}, pend_cause};
                priv_mode <= 1'b1;
            end
            if (state == ST_RETURN) begin
                priv_mode <= 1'b0;
            end
        end
    end

    always_comb begin
        next           = state;
        stall_id       = 1'b0;
        flush_all      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    next = priv_mode ? ST_HALT : ST_DRAIN_TRAP;
                end else if (is_ret) begin
                    next = ST_DRAIN_RET;
                end
            end
            ST_DRAIN_TRAP: begin
                stall_id  = 1'b1;
                flush_all = 1'b1;
                if (sb_empty) begin
                    next = ST_TRAP;
                end
            end
            ST_TRAP: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                next           = ST_IDLE;
            end
            ST_DRAIN_RET: begin
                stall_id = 1'b1;
                if (sb_empty) begin
                    next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                redirect_valid = 1'b1;
                redirect_pc    = rm0;
                flush_all      = 1'b1;
                next           = ST_IDLE;
            end
            ST_HALT: begin
                stall_id = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                next = ST_IDLE;
            end
        endcase
    end

`ifdef EXC_TRAP_COUNT_EN
    logic [31:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == ST_TRAP) begin
            count <= count + 32'd1;
        end
    end

    assign trap_count = count;
`else
    assign trap_count = '0;
`endif

endmodule

// File: tb/tb_exception_controller.sv
// Directed cycle-table bench for exception_controller.
module tb_exception_controller;

    localparam int OP_NONE  = 0;
    localparam int OP_PANIC = 1;
    localparam int OP_IRET  = 2;
    localparam int OP_TLBW  = 3;
    localparam int OP_MOVRM = 4;
    localparam int OP_EXC   = 5;

    typedef struct {
        int          op;
        logic [31:0] pc;
        logic        sbe;
        logic [4:0]  o;
        logic [31:0] rpc;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_panic, id_iret, id_tlbwrite, id_mov_rm;
    logic [31:0] id_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_addr;
    logic        sb_empty;
    logic        stall_id, flush_all, redirect_valid, priv_mode, halted;
    logic [31:0] redirect_pc, rm0, rm1, rm2, trap_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_controller dut (
        .clk            (clk),
        .reset          (rst_n),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_panic       (id_panic),
        .id_iret        (id_iret),
        .id_tlbwrite    (id_tlbwrite),
        .id_mov_rm      (id_mov_rm),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_addr       (exc_addr),
        .sb_empty       (sb_empty),
        .stall_id       (stall_id),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rm0            (rm0),
        .rm1            (rm1),
        .rm2            (rm2),
        .priv_mode      (priv_mode),
        .halted         (halted),
        .trap_count     (trap_count)
    );

    // o = {stall, flush, redirect_valid, priv_mode, halted}
    function automatic vec_t mk(input int op, input logic [31:0] pc,
                                input logic sbe, input logic [4:0] o,
                                input logic [31:0] rpc, input logic [31:0] r0,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.pc = pc; v.sbe = sbe; v.o = o;
        v.rpc = rpc; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [164:0] expv(input vec_t v);
        logic [31:0] c;
`ifdef EXC_TRAP_COUNT_EN
        c = v.cnt;
`else
        c = 32'd0;
`endif
        return {v.o[4], v.o[3], v.o[2], v.rpc, v.r0, v.r1, v.r2,
                v.o[1], v.o[0], c};
    endfunction

    task automatic check(input string name, input logic [164:0] exp);
        logic [164:0] act;
        act = {stall_id, flush_all, redirect_valid, redirect_pc,
               rm0, rm1, rm2, priv_mode, halted, trap_count};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid    = (v.op != OP_NONE);
        id_pc       = v.pc;
        id_panic    = (v.op == OP_PANIC);
        id_iret     = (v.op == OP_IRET) || (v.op == OP_EXC);
        id_tlbwrite = (v.op == OP_TLBW);
        id_mov_rm   = (v.op == OP_MOVRM);
        exc_valid   = (v.op == OP_EXC);
        exc_cause   = (v.op == OP_EXC) ? 4'd3 : 4'd0;
        exc_pc      = (v.op == OP_EXC) ? 32'h1100 : 32'h0;
        exc_addr    = (v.op == OP_EXC) ? 32'h8000 : 32'h0;
        sb_empty    = v.sbe;
    endtask

    task automatic run_row(input vec_t v, input string name);
        @(negedge clk);
        check(name, expv(v));
        drive(v);
    endtask

    vec_t tv[$];
    vec_t rst_v;

    initial begin
        rst_v = mk(OP_NONE, 0, 1, 5'b00010, 0, 0, 0, 0, 0);

        // Supervisor iret with rm0=0 to reach user mode
        tv.push_back(mk(OP_IRET,  0,      1, 5'b00010, 0,      0,      0,      0, 0));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b10010, 0,      0,      0,      0, 0));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b01110, 0,      0,      0,      0, 0));
        // User panic at 0x1040, store buffer already empty
        tv.push_back(mk(OP_PANIC, 'h1040, 1, 5'b00000, 0,      0,      0,      0, 0));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b11000, 0,      0,      0,      0, 0));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b00100, 'h2000, 0,      0,      0, 0));
        // Supervisor tlbwrite / mov_rm: no action
        tv.push_back(mk(OP_TLBW,  0,      1, 5'b00010, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_MOVRM, 0,      1, 5'b00010, 0,      'h1040, 0,      1, 1));
        // Return with slow drain; exc_valid during drain ignored
        tv.push_back(mk(OP_IRET,  0,      1, 5'b00010, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      0, 5'b10010, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_EXC,   0,      0, 5'b10010, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b10010, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b01110, 'h1040, 'h1040, 0,      1, 1));
        // DTLB miss with iret in decode the same cycle, 5-cycle drain
        tv.push_back(mk(OP_EXC,   0,      1, 5'b00000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      0, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_PANIC, 'h1234, 0, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      0, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      0, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      0, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b11000, 0,      'h1040, 0,      1, 1));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b00100, 'h2000, 'h1040, 0,      1, 1));
        // Back to user at 0x1100
        tv.push_back(mk(OP_IRET,  0,      1, 5'b00010, 0,      'h1100, 'h8000, 3, 2));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b10010, 0,      'h1100, 'h8000, 3, 2));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b01110, 'h1100, 'h1100, 'h8000, 3, 2));
        // User tlbwrite -> PRIV trap
        tv.push_back(mk(OP_TLBW,  'h1044, 1, 5'b00000, 0,      'h1100, 'h8000, 3, 2));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b11000, 0,      'h1100, 'h8000, 3, 2));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b00100, 'h2000, 'h1100, 'h8000, 3, 2));
        // Return to 0x1044
        tv.push_back(mk(OP_IRET,  0,      1, 5'b00010, 0,      'h1044, 0,      4, 3));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b10010, 0,      'h1044, 0,      4, 3));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b01110, 'h1044, 'h1044, 0,      4, 3));
        // User mov_rm -> PRIV trap
        tv.push_back(mk(OP_MOVRM, 'h1050, 1, 5'b00000, 0,      'h1044, 0,      4, 3));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b11000, 0,      'h1044, 0,      4, 3));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b00100, 'h2000, 'h1044, 0,      4, 3));
        // Supervisor panic -> HALT, sticky
        tv.push_back(mk(OP_PANIC, 'h1060, 1, 5'b00010, 0,      'h1050, 0,      4, 4));
        tv.push_back(mk(OP_EXC,   0,      1, 5'b10011, 0,      'h1050, 0,      4, 4));
        tv.push_back(mk(OP_NONE,  0,      1, 5'b10011, 0,      'h1050, 0,      4, 4));

        rst_n = 1'b0;
        drive(mk(OP_NONE, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("reset", expv(rst_v));
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            run_row(tv[i], $sformatf("row%0d", i));
        end

        // Reset clears HALT
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("halt_reset", expv(rst_v));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in DRAIN_TRAP: no redirect, no rm update
        run_row(mk(OP_IRET, 0, 1, 5'b00010, 0, 0, 0, 0, 0), "hs_iret");
        run_row(mk(OP_NONE, 0, 1, 5'b10010, 0, 0, 0, 0, 0), "hs_dret");
        run_row(mk(OP_NONE, 0, 1, 5'b01110, 0, 0, 0, 0, 0), "hs_ret");
        run_row(mk(OP_PANIC, 'h1070, 0, 5'b00000, 0, 0, 0, 0, 0), "hs_user");
        run_row(mk(OP_NONE, 0, 0, 5'b11000, 0, 0, 0, 0, 0), "hs_drain");
        #2 rst_n = 1'b0;
        #1 check("mid_reset", expv(rst_v));
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(OP_NONE, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            run_row(mk(OP_NONE, 0, 1, 5'b00010, 0, 0, 0, 0, 0),
                    $sformatf("post_reset%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
